// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   MEM stage of the 16-bit pipeline, directly downstream of the EXE/MEM
//   register. Loads and stores run a multi-cycle cycle on an external async
//   SRAM through a small FSM. While an access is in flight, mem_stall freezes
//   the pipeline. The stage also selects the write-back value for the
//   MEM/WB register.
//
// Ports
//   clk_50MHz       in     system clock, rising edge
//   rst             in     asynchronous reset, active low
//   em_RAM_en       in     1 = this instruction accesses memory
//   em_RAM_op       in     0 = read, 1 = write
//   em_WB_DATA_op   in     write-back source: 0 ALU, 1 MEM, 2 PC, 3 IH
//   em_REG_op       in     register-write control, passed through
//   em_IH           in     IH value for the IH write-back source
//   em_PC           in     PC value for the PC write-back source
//   em_ALU_data     in     ALU result; also the memory address
//   em_RAM_WB_data  in     store data
//   em_WB_addr      in     destination register, passed through
//   mem_stall       out    1 = hazard unit must hold all pipeline registers
//   n_mw_WB_data    out    selected write-back data
//   n_mw_REG_op     out    em_REG_op, or NOP while stalled
//   n_mw_WB_addr    out    em_WB_addr passthrough
//   ram_addr        out    SRAM address (zero-extended ALU result)
//   ram_data        inout  SRAM data bus, high-Z unless writing
//   ram_ce_n        out    SRAM chip enable, active low
//   ram_oe_n        out    SRAM output enable, active low
//   ram_we_n        out    SRAM write enable, active low
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 18,
    parameter int REG_OP_W = 2,
    parameter int WB_OP_W  = 2
) (
    input  logic                clk_50MHz,
    input  logic                rst,
    input  logic                em_RAM_en,
    input  logic                em_RAM_op,
    input  logic [WB_OP_W-1:0]  em_WB_DATA_op,
    input  logic [REG_OP_W-1:0] em_REG_op,
    input  logic [DATA_W-1:0]   em_IH,
    input  logic [DATA_W-1:0]   em_PC,
    input  logic [DATA_W-1:0]   em_ALU_data,
    input  logic [DATA_W-1:0]   em_RAM_WB_data,
    input  logic [3:0]          em_WB_addr,
    output logic                mem_stall,
    output logic [DATA_W-1:0]   n_mw_WB_data,
    output logic [REG_OP_W-1:0] n_mw_REG_op,
    output logic [3:0]          n_mw_WB_addr,
    output logic [ADDR_W-1:0]   ram_addr,
    inout  wire  [DATA_W-1:0]   ram_data,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n
);

    localparam logic                RAM_OP_RD  = 1'b0;
    localparam logic [REG_OP_W-1:0] REG_OP_NOP = '0;
    localparam logic [WB_OP_W-1:0]  WB_SEL_ALU = WB_OP_W'(0);
    localparam logic [WB_OP_W-1:0]  WB_SEL_MEM = WB_OP_W'(1);
    localparam logic [WB_OP_W-1:0]  WB_SEL_PC  = WB_OP_W'(2);
    localparam logic [WB_OP_W-1:0]  WB_SEL_IH  = WB_OP_W'(3);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rd_buf;
    logic                data_oe;

    function automatic logic [ADDR_W-1:0] zext_addr(input logic [DATA_W-1:0] a);
        return ADDR_W'(a);
    endfunction

    // The bus is only ever driven in WR1..WR3, and oe_n is only low in
    // RD1..RD2, so the SRAM and this stage can never fight over ram_data.
    assign ram_data = data_oe ? wdata_q : {DATA_W{1'bz}};

    // The access is accepted in IDLE, so the stall must already be high there
    // to keep the EXE/MEM register holding the instruction. DONE drops the
    // stall so the pipeline advances on the edge that leaves DONE.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE:                    mem_stall = em_RAM_en;
            RD1, RD2, WR1, WR2, WR3: mem_stall = 1'b1;
            default:                 mem_stall = 1'b0;
        endcase
    end

    always_comb begin
        n_mw_WB_data = em_ALU_data;
        case (em_WB_DATA_op)
            WB_SEL_ALU: n_mw_WB_data = em_ALU_data;
            WB_SEL_MEM: n_mw_WB_data = rd_buf;
            WB_SEL_PC:  n_mw_WB_data = em_PC;
            WB_SEL_IH:  n_mw_WB_data = em_IH;
            default:    n_mw_WB_data = em_ALU_data;
        endcase
    end

    // A stalled cycle is a bubble: suppressing REG_op avoids writing the same
    // result back once per stalled cycle.
    assign n_mw_REG_op  = mem_stall ? REG_OP_NOP : em_REG_op;
    assign n_mw_WB_addr = em_WB_addr;

    // Strobes, address and bus enable are all registered: each is loaded on
    // the edge that enters the state in which it must be valid.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            data_oe  <= 1'b0;
            ram_addr <= '0;
            rd_buf   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (em_RAM_en) begin
                        addr_q   <= zext_addr(em_ALU_data);
                        wdata_q  <= em_RAM_WB_data;
                        ram_addr <= zext_addr(em_ALU_data);
                        ram_ce_n <= 1'b0;
                        if (em_RAM_op == RAM_OP_RD) begin
                            ram_oe_n <= 1'b0;
                            state    <= RD1;
                        end else begin
                            data_oe  <= 1'b1;
                            state    <= WR1;
                        end
                    end
                end
                RD1: begin
                    ram_addr <= addr_q;
                    state    <= RD2;
                end
                RD2: begin
                    // Sampled while oe_n is still low; the strobes release
                    // on this same edge.
                    rd_buf   <= ram_data;
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    state    <= DONE;
                end
                WR1: begin
                    ram_addr <= addr_q;
                    ram_we_n <= 1'b0;
                    state    <= WR2;
                end
                WR2: begin
                    // Rising we_n is the SRAM write point; address and data
                    // stay driven through WR3 for hold time.
                    ram_we_n <= 1'b1;
                    state    <= WR3;
                end
                WR3: begin
                    ram_ce_n <= 1'b1;
                    data_oe  <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    data_oe  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
